// File: rtl/mod_shiftrows_seq.sv
// mod_shiftrows_seq
//   Sequential AES/Rijndael ShiftRows / InvShiftRows engine. It accepts a 4 x NB
//   state over a valid/ready handshake, rotates one row per clock and then presents
//   the result until downstream takes it. The direction is chosen per transaction.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
//   The producer holds valid and data stable until that edge. Ready may be computed
//   from any signal. It never depends combinationally on valid.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous reset, active HIGH (1 = reset) despite the name
//   in_valid   in_state / in_inv are valid
//   in_ready   block can accept a state (IDLE only)
//   in_inv     0 = ShiftRows, 1 = InvShiftRows; sampled on accept
//   in_state   4*NB*W bits; element (r,c) at [(4*c+r)*W +: W]
//   out_valid  out_state holds the finished result
//   out_ready  downstream accepts the result
//   out_state  shifted state, same layout as in_state; driven only from the work register
//   busy       high while shifting or holding a result
module mod_shiftrows_seq #(
  parameter int NB = 4,
  parameter int W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [4*NB*W-1:0] in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NB*W-1:0] out_state,
  output logic              busy
);

  localparam int SW = 4 * NB * W;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
    $error("mod_shiftrows_seq: NB must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      row_cnt_q, row_cnt_d;
  logic [SW-1:0]   work_q, work_d;
  logic            inv_q, inv_d;
  logic            out_valid_q, out_valid_d;
  logic [SW-1:0]   rot_state;

  // Rijndael row offsets. The wide block (NB = 8) uses 0,1,3,4 and the others use 0,1,2,3.
  function automatic int row_off(input int r);
    int off;
    case (r)
      0:       off = 0;
      1:       off = 1;
      2:       off = (NB == 8) ? 3 : 2;
      default: off = (NB == 8) ? 4 : 3;
    endcase
    return off;
  endfunction

  // Source column for destination column c of row r.
  function automatic int src_col(input int c, input int r, input logic inv);
    int s;
    if (inv) s = (c - row_off(r) + NB) % NB;
    else     s = (c + row_off(r)) % NB;
    return s;
  endfunction

  // The work register with only the row selected by row_cnt rotated.
  always_comb begin
    rot_state = work_q;
    for (int r = 0; r < 4; r++) begin
      if (r == int'(row_cnt_q)) begin
        for (int c = 0; c < NB; c++) begin
          rot_state[(4*c+r)*W +: W] = work_q[(4*src_col(c, r, inv_q)+r)*W +: W];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    work_d      = work_q;
    inv_d       = inv_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d    = in_state;
          inv_d     = in_inv;
          row_cnt_d = 2'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Row 0 is an identity rotation but still takes a cycle, so the latency is fixed.
        work_d    = rot_state;
        row_cnt_d = row_cnt_q + 2'd1;
        if (row_cnt_q == 2'd3) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q     <= IDLE;
      row_cnt_q   <= 2'd0;
      work_q      <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      work_q      <= work_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT) || (state_q == HOLD);
  assign out_valid = out_valid_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_mod_shiftrows_seq.sv
module tb_mod_shiftrows_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  // ---------------- NB = 4 instance ----------------
  logic         in_valid4 = 1'b0, in_inv4 = 1'b0, out_ready4 = 1'b0;
  logic         in_ready4, out_valid4, busy4;
  logic [127:0] in_state4 = '0;
  logic [127:0] out_state4;

  mod_shiftrows_seq #(.NB(4), .W(8)) dut4 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_inv(in_inv4), .in_state(in_state4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_state(out_state4), .busy(busy4)
  );

  // ---------------- NB = 8 instance ----------------
  logic         in_valid8 = 1'b0, in_inv8 = 1'b0, out_ready8 = 1'b0;
  logic         in_ready8, out_valid8, busy8;
  logic [255:0] in_state8 = '0;
  logic [255:0] out_state8;

  mod_shiftrows_seq #(.NB(8), .W(8)) dut8 (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8), .in_state(in_state8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_state(out_state8), .busy(busy8)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  logic [255:0] exp_q[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_pop(input string tag, input logic [255:0] obs);
    logic [255:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check(tag, obs, e);
  endtask

  // ---------------- drivers ----------------
  task automatic run4(input logic [127:0] st, input logic inv, output int lat);
    @(negedge clk);
    in_valid4 = 1'b1; in_state4 = st; in_inv4 = inv;
    @(posedge clk); #1;
    // Scramble the inputs after accept; they must not affect the result.
    in_valid4 = 1'b0; in_state4 = ~st; in_inv4 = ~inv;
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run8(input logic [255:0] st, input logic inv, output int lat);
    @(negedge clk);
    in_valid8 = 1'b1; in_state8 = st; in_inv8 = inv;
    @(posedge clk); #1;
    in_valid8 = 1'b0; in_state8 = ~st; in_inv8 = ~inv;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume4();
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  task automatic consume8();
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  // ---------------- vectors ----------------
  localparam logic [127:0] SEQ_IN   = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] SEQ_ENC  = 128'h0b06010c07020d08030e09040f0a0500;
  localparam logic [127:0] FIPS_IN  = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam logic [127:0] FIPS_ENC = 128'he598271ef11141b8ae52b4e0305dbfd4;

  logic [7:0] exp8_rows [4][8] = '{
    '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07},
    '{8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'h08},
    '{8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h10, 8'h11, 8'h12},
    '{8'h1c, 8'h1d, 8'h1e, 8'h1f, 8'h18, 8'h19, 8'h1a, 8'h1b}
  };

  initial begin
    int lat;
    logic [127:0] held;
    logic [255:0] st8, ex8;
    logic [63:0] row_obs, row_exp;

    // Power-on reset, released at a falling edge.
    repeat (3) @(posedge clk);
    @(negedge clk); resetn = 1'b0;
    #1;
    check("por_in_ready", 256'(in_ready4), 256'(1'b1));
    check("por_out_valid", 256'(out_valid4), 256'(1'b0));
    check("por_busy", 256'(busy4), 256'(1'b0));
    check("por_out_state", 256'(out_state4), 256'(0));

    // Test 2: NB=4 enc of 00..0f with fixed 4-edge latency.
    exp_q.push_back(256'(SEQ_ENC));
    run4(SEQ_IN, 1'b0, lat);
    check("seq_latency", 256'(lat), 256'(4));
    check_pop("seq_enc", 256'(out_state4));
    check("seq_busy_hold", 256'(busy4), 256'(1'b1));
    consume4();
    check("seq_back_idle", 256'(in_ready4), 256'(1'b1));

    // Test 3: FIPS-197 round 1, enc then inv of the result.
    exp_q.push_back(256'(FIPS_ENC));
    run4(FIPS_IN, 1'b0, lat);
    check("fips_enc_latency", 256'(lat), 256'(4));
    check_pop("fips_enc", 256'(out_state4));
    consume4();
    exp_q.push_back(256'(FIPS_IN));
    run4(FIPS_ENC, 1'b1, lat);
    check("fips_inv_latency", 256'(lat), 256'(4));
    check_pop("fips_inv", 256'(out_state4));
    consume4();

    // Test 4: backpressure in HOLD; a stray in_valid must not be captured.
    run4(SEQ_IN, 1'b0, lat);
    held = SEQ_ENC;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid4 = 1'b1; in_state4 = FIPS_IN; in_inv4 = 1'b0;
      end else begin
        in_valid4 = 1'b0;
      end
      @(posedge clk); #1;
      check("bp_out_state", 256'(out_state4), 256'(held));
      check("bp_in_ready", 256'(in_ready4), 256'(1'b0));
      check("bp_out_valid", 256'(out_valid4), 256'(1'b1));
    end
    in_valid4 = 1'b0;
    consume4();
    check("bp_idle_in_ready", 256'(in_ready4), 256'(1'b1));
    check("bp_idle_out_valid", 256'(out_valid4), 256'(1'b0));
    check("bp_no_capture", 256'(out_state4), 256'(held));

    // Test 1: reset asserted mid-run (while holding a result) clears outputs at once.
    run4(FIPS_IN, 1'b0, lat);
    #2 resetn = 1'b1;
    #1;
    check("rst_in_ready", 256'(in_ready4), 256'(1'b1));
    check("rst_out_valid", 256'(out_valid4), 256'(1'b0));
    check("rst_busy", 256'(busy4), 256'(1'b0));
    check("rst_out_state", 256'(out_state4), 256'(0));
    @(negedge clk); resetn = 1'b0;

    // Test 5: reset after two SHIFT rows aborts; no out_valid follows.
    @(negedge clk);
    in_valid4 = 1'b1; in_state4 = SEQ_IN; in_inv4 = 1'b0;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    check("abort_busy", 256'(busy4), 256'(1'b0));
    check("abort_out_state", 256'(out_state4), 256'(0));
    @(negedge clk); resetn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_valid", 256'(out_valid4), 256'(1'b0));
    end
    exp_q.push_back(256'(SEQ_ENC));
    run4(SEQ_IN, 1'b0, lat);
    check("after_abort_latency", 256'(lat), 256'(4));
    check_pop("after_abort_enc", 256'(out_state4));
    consume4();

    // Test 6: NB=8 enc with element (r,c) = 8*r+c, then inv back.
    st8 = '0;
    ex8 = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        st8[(4*c+r)*8 +: 8] = 8'(8*r + c);
        ex8[(4*c+r)*8 +: 8] = exp8_rows[r][c];
      end
    end
    exp_q.push_back(ex8);
    run8(st8, 1'b0, lat);
    check("nb8_latency", 256'(lat), 256'(4));
    for (int r = 2; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        row_obs[c*8 +: 8] = out_state8[(4*c+r)*8 +: 8];
        row_exp[c*8 +: 8] = exp8_rows[r][c];
      end
      check((r == 2) ? "nb8_row2" : "nb8_row3", 256'(row_obs), 256'(row_exp));
    end
    check_pop("nb8_enc", out_state8);
    consume8();
    exp_q.push_back(st8);
    run8(ex8, 1'b1, lat);
    check_pop("nb8_inv", out_state8);
    consume8();
    check("nb8_idle", 256'(in_ready8), 256'(1'b1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
